// File: rtl/mmio_pkg.sv
// Shared definitions for the MMIO/sonar bridge: register offsets inside the
// MMIO window and the per-channel echo capture state encoding.
package mmio_pkg;

   localparam logic [3:0] OFF_LED        = 4'h0;
   localparam logic [3:0] OFF_CYC        = 4'h1;
   localparam logic [3:0] OFF_STAT       = 4'h2;
   localparam logic [3:0] OFF_WIDTH_BASE = 4'h8;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      MEAS     = 2'd1,
      WAIT_LOW = 2'd2
   } ch_state_e;

endpackage

// File: rtl/echo_capture.sv
// One sonar echo channel: 2-FF synchroniser, edge detect, pulse-width counter
// with timeout, and a width/valid result pair that software can clear.
module echo_capture
   import mmio_pkg::*;
#(
   parameter int unsigned TIMEOUT = 1_500_000,
   parameter int unsigned CNT_W   = $clog2(TIMEOUT + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             echo,
   input  logic             clr,
   output logic [CNT_W-1:0] width,
   output logic             valid
);

   // [1:0] is the synchroniser, [2] holds the previous synchronised level.
   logic [2:0]       sync_q, sync_d;
   ch_state_e        state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] width_q, width_d;
   logic             valid_q, valid_d;
   logic             level, rise, set_valid;

   assign level = sync_q[1];
   assign rise  = sync_q[1] & ~sync_q[2];

   // NOTE: every signal driven here gets a default first, so no path can
   // leave it unassigned and infer a latch.
   always_comb begin
      sync_d    = {sync_q[1:0], echo};
      state_d   = state_q;
      cnt_d     = cnt_q;
      width_d   = width_q;
      set_valid = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (rise) begin
               state_d = MEAS;
               cnt_d   = CNT_W'(1);
            end
         end
         MEAS: begin
            if (level) begin
               if (cnt_q < CNT_W'(TIMEOUT - 1)) begin
                  cnt_d = cnt_q + CNT_W'(1);
               end else begin
                  width_d   = CNT_W'(TIMEOUT);
                  set_valid = 1'b1;
                  state_d   = WAIT_LOW;
               end
            end else begin
               width_d   = cnt_q;
               set_valid = 1'b1;
               state_d   = IDLE;
            end
         end
         WAIT_LOW: begin
            if (!level) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      // A fresh capture beats a same-cycle software clear.
      valid_d = set_valid | (valid_q & ~clr);
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q  <= '0;
         state_q <= IDLE;
         cnt_q   <= '0;
         width_q <= '0;
         valid_q <= 1'b0;
      end else begin
         sync_q  <= sync_d;
         state_q <= state_d;
         cnt_q   <= cnt_d;
         width_q <= width_d;
         valid_q <= valid_d;
      end
   end

   assign width = width_q;
   assign valid = valid_q;

endmodule

// File: rtl/mmio_sonar_bridge.sv
// Data-memory-side bridge: splits processor dmem accesses between RAM and an
// MMIO window holding LEDs, a cycle counter and NUM_CH echo width captures.
module mmio_sonar_bridge
   import mmio_pkg::*;
#(
   parameter int unsigned ADDR_W  = 12,
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned LED_W   = 16,
   parameter int unsigned NUM_CH  = 4,
   parameter int unsigned TIMEOUT = 1_500_000
) (
   input  logic              CLK,
   input  logic              CPU_RESETN,
   input  logic              wren,
   input  logic [ADDR_W-1:0] address_dmem,
   input  logic [DATA_W-1:0] data,
   output logic [DATA_W-1:0] q_dmem,
   output logic              ram_wEn,
   output logic [ADDR_W-2:0] ram_addr,
   output logic [DATA_W-1:0] ram_dataIn,
   input  logic [DATA_W-1:0] ram_dataOut,
   input  logic [NUM_CH-1:0] echo,
   output logic [LED_W-1:0]  LED
);

   localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

   logic              ram_sel;
   logic              mmio_wr, mmio_rd;
   logic [3:0]        off;
   logic              sel_q, sel_d;
   logic [LED_W-1:0]  led_q, led_d;
   logic [DATA_W-1:0] cyc_q, cyc_d;
   logic [DATA_W-1:0] mmio_rdata_q, mmio_rdata_d;
   logic [NUM_CH-1:0] valid, clr;
   logic [CNT_W-1:0]  width [NUM_CH];

   assign ram_sel    = ~address_dmem[ADDR_W-1];
   assign off        = address_dmem[3:0];
   assign mmio_wr    = wren & ~ram_sel;
   assign mmio_rd    = ~wren & ~ram_sel;
   assign ram_wEn    = wren & ram_sel;
   assign ram_addr   = address_dmem[ADDR_W-2:0];
   assign ram_dataIn = data;

   always_comb begin
      sel_d = ram_sel;
      cyc_d = cyc_q + DATA_W'(1);
      led_d = led_q;
      if (mmio_wr && off == OFF_LED) led_d = data[LED_W-1:0];

      // Status W1C and width-register reads both retire a channel's result.
      clr = '0;
      for (int unsigned ch = 0; ch < NUM_CH; ch++) begin
         if (mmio_wr && off == OFF_STAT && data[ch]) clr[ch] = 1'b1;
         if (mmio_rd && off == 4'(OFF_WIDTH_BASE + ch)) clr[ch] = 1'b1;
      end

      mmio_rdata_d = '0;
      case (off)
         OFF_LED:  mmio_rdata_d = DATA_W'(led_q);
         OFF_CYC:  mmio_rdata_d = cyc_q;
         OFF_STAT: mmio_rdata_d = DATA_W'(valid);
         default:  mmio_rdata_d = '0;
      endcase
      for (int unsigned ch = 0; ch < NUM_CH; ch++) begin
         if (off == 4'(OFF_WIDTH_BASE + ch)) mmio_rdata_d = DATA_W'(width[ch]);
      end
   end

   always_ff @(posedge CLK or negedge CPU_RESETN) begin
      if (!CPU_RESETN) begin
         sel_q        <= 1'b0;
         led_q        <= '0;
         cyc_q        <= '0;
         mmio_rdata_q <= '0;
      end else begin
         sel_q        <= sel_d;
         led_q        <= led_d;
         cyc_q        <= cyc_d;
         mmio_rdata_q <= mmio_rdata_d;
      end
   end

   // RAM data already arrives one cycle late, so both paths line up here.
   assign q_dmem = sel_q ? ram_dataOut : mmio_rdata_q;
   assign LED    = led_q;

   for (genvar g = 0; g < int'(NUM_CH); g++) begin : g_ch
      echo_capture #(
         .TIMEOUT (TIMEOUT)
      ) u_cap (
         .clk   (CLK),
         .rst_n (CPU_RESETN),
         .echo  (echo[g]),
         .clr   (clr[g]),
         .width (width[g]),
         .valid (valid[g])
      );
   end

endmodule

// File: tb/tb_mmio_sonar_bridge.sv
// Scoreboarded bench: reads push expected data, a monitor compares q_dmem one
// cycle later. A second instance with a short timeout covers echo overflow.
module tb_mmio_sonar_bridge;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        wren = 1'b0;
   logic [11:0] addr = '0;
   logic [31:0] data = '0;
   logic [3:0]  echo = '0;
   logic [3:0]  echo_to = '0;

   logic [31:0] q_main, q_to;
   logic        ram_wEn, ram_wEn_to;
   logic [10:0] ram_addr, ram_addr_to;
   logic [31:0] ram_dataIn, ram_dataIn_to;
   logic [31:0] ram_dataOut;
   logic [15:0] led, led_to;

   logic [31:0] mem [2048];

   typedef struct {
      bit          to;
      logic [31:0] exp;
      string       name;
   } sb_item_t;

   sb_item_t sb[$];
   logic     rd_issue = 1'b0;
   logic     rd_pipe = 1'b0;
   int       n_checks = 0;
   int       n_fail = 0;

   always #5 clk = ~clk;

   mmio_sonar_bridge u_dut (
      .CLK          (clk),
      .CPU_RESETN   (rst_n),
      .wren         (wren),
      .address_dmem (addr),
      .data         (data),
      .q_dmem       (q_main),
      .ram_wEn      (ram_wEn),
      .ram_addr     (ram_addr),
      .ram_dataIn   (ram_dataIn),
      .ram_dataOut  (ram_dataOut),
      .echo         (echo),
      .LED          (led)
   );

   mmio_sonar_bridge #(.TIMEOUT(50)) u_to (
      .CLK          (clk),
      .CPU_RESETN   (rst_n),
      .wren         (wren),
      .address_dmem (addr),
      .data         (data),
      .q_dmem       (q_to),
      .ram_wEn      (ram_wEn_to),
      .ram_addr     (ram_addr_to),
      .ram_dataIn   (ram_dataIn_to),
      .ram_dataOut  (32'h0),
      .echo         (echo_to),
      .LED          (led_to)
   );

   // Synchronous RAM model with 1-cycle read latency.
   always @(posedge clk) begin
      if (ram_wEn) mem[ram_addr] <= ram_dataIn;
      ram_dataOut <= mem[ram_addr];
   end

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   always @(posedge clk) rd_pipe <= rd_issue;

   always @(negedge clk) begin
      if (rd_pipe) begin
         if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL sb_underflow: got read with no expected entry");
         end else begin
            sb_item_t it;
            it = sb.pop_front();
            check(it.name, it.to ? q_to : q_main, it.exp);
         end
      end
   end

   task automatic drive(bit w, logic [11:0] a, logic [31:0] d, bit rd);
      @(posedge clk);
      #1;
      wren     = w;
      addr     = a;
      data     = d;
      rd_issue = rd;
   endtask

   task automatic idle();
      drive(1'b0, 12'h000, 32'h0, 1'b0);
   endtask

   task automatic rd(logic [11:0] a, logic [31:0] exp, bit to, string name);
      sb_item_t it;
      it.to   = to;
      it.exp  = exp;
      it.name = name;
      sb.push_back(it);
      drive(1'b0, a, 32'h0, 1'b1);
   endtask

   task automatic pulse(int ch, int n);
      @(posedge clk);
      #1 echo[ch] = 1'b1;
      repeat (n) @(posedge clk);
      #1 echo[ch] = 1'b0;
   endtask

   initial begin
      // Power-on reset
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("por_led", 32'(led), 32'h0);
      check("por_q", q_main, 32'h0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      rd(12'h802, 32'h0, 1'b0, "por_status");
      idle();

      // RAM passthrough
      drive(1'b1, 12'h005, 32'hDEADBEEF, 1'b0);
      @(negedge clk);
      check("ram_wen_store", 32'(ram_wEn), 32'h1);
      check("ram_addr_store", 32'(ram_addr), 32'h005);
      check("ram_din_store", ram_dataIn, 32'hDEADBEEF);
      check("ram_wen_store_to", 32'(ram_wEn_to), 32'h1);
      rd(12'h005, 32'hDEADBEEF, 1'b0, "ram_load_005");
      @(negedge clk);
      check("ram_wen_load", 32'(ram_wEn), 32'h0);
      drive(1'b1, 12'h7FF, 32'h0BADF00D, 1'b0);
      rd(12'h7FF, 32'h0BADF00D, 1'b0, "ram_load_7ff");
      rd(12'h005, 32'hDEADBEEF, 1'b0, "ram_reload_005");
      idle();

      // LED register and unmapped offsets
      drive(1'b1, 12'h800, 32'h1234ABCD, 1'b0);
      @(negedge clk);
      check("ram_wen_mmio", 32'(ram_wEn), 32'h0);
      check("ram_addr_mmio_to", 32'(ram_addr_to), 32'h000);
      check("ram_din_mmio_to", ram_dataIn_to, 32'h1234ABCD);
      idle();
      @(negedge clk);
      check("led_write", 32'(led), 32'h0000ABCD);
      check("led_write_to", 32'(led_to), 32'h0000ABCD);
      rd(12'h800, 32'h0000ABCD, 1'b0, "led_read");
      drive(1'b1, 12'h803, 32'hFFFFFFFF, 1'b0);
      idle();
      @(negedge clk);
      check("led_unmapped_wr", 32'(led), 32'h0000ABCD);
      rd(12'h803, 32'h0, 1'b0, "unmapped_803");
      rd(12'h80F, 32'h0, 1'b0, "unmapped_80f");
      idle();

      // Echo width on channel 1, then channel 3
      pulse(1, 100);
      repeat (3) @(posedge clk);
      rd(12'h802, 32'h2, 1'b0, "stat_ch1_set");
      rd(12'h809, 32'd100, 1'b0, "width_ch1");
      rd(12'h802, 32'h0, 1'b0, "stat_ch1_clr");
      idle();
      pulse(3, 7);
      repeat (3) @(posedge clk);
      rd(12'h802, 32'h8, 1'b0, "stat_ch3_set");
      rd(12'h80B, 32'd7, 1'b0, "width_ch3");
      rd(12'h809, 32'd100, 1'b0, "width_ch1_held");
      rd(12'h802, 32'h0, 1'b0, "stat_ch3_clr");
      idle();

      // Timeout on the TIMEOUT=50 instance
      @(posedge clk);
      #1 echo_to[0] = 1'b1;
      repeat (60) @(posedge clk);
      rd(12'h802, 32'h1, 1'b1, "to_stat_set");
      rd(12'h808, 32'd50, 1'b1, "to_width");
      idle();
      repeat (17) @(posedge clk);
      #1 echo_to[0] = 1'b0;
      repeat (5) @(posedge clk);
      rd(12'h802, 32'h0, 1'b1, "to_no_recapture");
      idle();
      @(posedge clk);
      #1 echo_to[0] = 1'b1;
      repeat (20) @(posedge clk);
      #1 echo_to[0] = 1'b0;
      repeat (3) @(posedge clk);
      rd(12'h802, 32'h1, 1'b1, "to_stat_second");
      rd(12'h808, 32'd20, 1'b1, "to_width_second");
      idle();

      // W1C in the same cycle a channel-2 capture lands
      pulse(2, 10);
      @(posedge clk);
      drive(1'b1, 12'h802, 32'h4, 1'b0);
      idle();
      rd(12'h802, 32'h4, 1'b0, "w1c_collide_stat");
      rd(12'h80A, 32'd10, 1'b0, "w1c_collide_width");
      idle();

      // Width read in the same cycle a newer capture lands
      pulse(2, 5);
      @(posedge clk);
      rd(12'h80A, 32'd10, 1'b0, "rd_collide_old");
      rd(12'h802, 32'h4, 1'b0, "rd_collide_stat");
      rd(12'h80A, 32'd5, 1'b0, "rd_collide_new");
      drive(1'b1, 12'h802, 32'h4, 1'b0);
      rd(12'h802, 32'h0, 1'b0, "w1c_plain");
      idle();

      // Reset during MEAS aborts the measurement; counter restarts
      @(posedge clk);
      #1 echo[3] = 1'b1;
      repeat (10) @(posedge clk);
      #1 rst_n = 1'b0;
      echo[3] = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_led", 32'(led), 32'h0);
      check("rst_q", q_main, 32'h0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      rd(12'h801, 32'd1, 1'b0, "cyc_restart_1");
      rd(12'h801, 32'd2, 1'b0, "cyc_restart_2");
      rd(12'h800, 32'h0, 1'b0, "rst_led_read");
      idle();
      repeat (5) @(posedge clk);
      rd(12'h802, 32'h0, 1'b0, "rst_meas_stat");
      rd(12'h80B, 32'h0, 1'b0, "rst_meas_width");
      idle();

      repeat (3) @(posedge clk);
      check("sb_drain", 32'(sb.size()), 32'h0);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
